// File: rtl/qk_pkg.sv
// Shared types and constants for the key collector: record layout, FSM states,
// frame constants and the popcount helper used for A/B key grading.
package qk_pkg;

  localparam int NCH              = 3;
  localparam int KEY_W            = 32;
  localparam int ERR_W            = 8;
  localparam int CH_W             = 2;
  localparam int MM_W             = $clog2(KEY_W + 1);
  localparam int DEF_FIFO_DEPTH   = 4;
  localparam int DEF_MISMATCH_MAX = 4;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         FRAME_LEN = 8;

  typedef struct packed {
    logic [CH_W-1:0]  ch;
    logic [MM_W-1:0]  mm;
    logic [ERR_W-1:0] err;
    logic [KEY_W-1:0] key;
  } qk_rec_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_CHECK,
    S_PUSH
  } qk_state_t;

  function automatic logic [MM_W-1:0] popcount(input logic [KEY_W-1:0] v);
    logic [MM_W-1:0] n;
    n = '0;
    for (int i = 0; i < KEY_W; i++) n = n + MM_W'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/qk_key_collector_if.sv
// Key-channel handshakes plus the byte-wide frame stream of the key collector.
// The collector is the slave; the key sources and the byte sink sit on the master side.
interface qk_key_collector_if;
  import qk_pkg::*;

  logic [NCH-1:0]       qk_valid;
  logic [NCH-1:0]       qk_ready;
  logic [NCH*ERR_W-1:0] qk_error;
  logic [NCH*KEY_W-1:0] qk_akey;
  logic [NCH*KEY_W-1:0] qk_bkey;
  logic [7:0]           tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (
    output qk_valid, qk_error, qk_akey, qk_bkey, tx_ready,
    input  qk_ready, tx_data, tx_valid
  );

  modport slave (
    input  qk_valid, qk_error, qk_akey, qk_bkey, tx_ready,
    output qk_ready, tx_data, tx_valid
  );

endinterface

// File: rtl/qk_rec_fifo.sv
// Synchronous record FIFO; push while full is accepted only when a pop retires
// the head in the same cycle, so a simultaneous push/pop keeps occupancy unchanged.
module qk_rec_fifo
  import qk_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  logic    pop,
  input  qk_rec_t din,
  output qk_rec_t head,
  output logic    full,
  output logic    empty
);
  localparam int AW = $clog2(DEPTH);

  qk_rec_t        mem [DEPTH];
  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/qk_key_collector.sv
// Collects key records from the key channels, grades A/B agreement and streams
// each buffered record as an 8-byte checksummed frame.
//  state   | meaning
//  S_IDLE  | wait for FIFO space and a valid channel, pick next round-robin
//  S_GRANT | ready to granted channel until its handshake
//  S_CHECK | mismatch popcount, build record
//  S_PUSH  | write record to FIFO, bump ok/abort counter
module qk_key_collector
  import qk_pkg::*;
#(
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
  parameter int MISMATCH_MAX = DEF_MISMATCH_MAX
) (
  input  logic              clk,
  input  logic              rst,
  qk_key_collector_if.slave qk,
  output logic [15:0]       key_ok_cnt,
  output logic [15:0]       key_abort_cnt
);
  localparam logic [MM_W-1:0] MM_LIMIT = MM_W'(MISMATCH_MAX);
  localparam logic [2:0]      LAST_IDX = 3'(FRAME_LEN - 1);

  qk_state_t        state_q;
  qk_state_t        state_d;
  logic [CH_W-1:0]  last_grant;
  logic [CH_W-1:0]  grant_q;
  logic [CH_W-1:0]  arb_ch;
  logic             arb_found;
  logic [ERR_W-1:0] err_q;
  logic [KEY_W-1:0] akey_q;
  logic [KEY_W-1:0] bkey_q;
  logic [MM_W-1:0]  mm;
  logic             abort;
  qk_rec_t          rec_q;
  qk_rec_t          head;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push_ok;
  logic             handshake;
  logic [2:0]       byte_idx;
  logic [7:0]       tx_byte;

  // First valid channel strictly after the previous grant, wrapping around.
  always_comb begin
    logic [CH_W-1:0] cand;
    cand      = '0;
    arb_found = 1'b0;
    arb_ch    = '0;
    for (int i = 1; i <= NCH; i++) begin
      cand = CH_W'((int'(last_grant) + i) % NCH);
      if (!arb_found && qk.qk_valid[cand]) begin
        arb_found = 1'b1;
        arb_ch    = cand;
      end
    end
  end

  assign mm        = popcount(akey_q ^ bkey_q);
  assign abort     = (mm > MM_LIMIT);
  assign push_ok   = ~fifo_full | fifo_pop;
  assign handshake = (state_q == S_GRANT) && qk.qk_valid[grant_q];

  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!fifo_full && arb_found) state_d = S_GRANT;
      S_GRANT: if (qk.qk_valid[grant_q])    state_d = S_CHECK;
      S_CHECK:                              state_d = S_PUSH;
      S_PUSH:  if (push_ok)                 state_d = S_IDLE;
      default:                              state_d = S_IDLE;
    endcase
  end

  always_comb begin
    qk.qk_ready = '0;
    fifo_push   = 1'b0;
    case (state_q)
      S_GRANT: qk.qk_ready[grant_q] = 1'b1;
      S_PUSH:  fifo_push = push_ok;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_grant    <= CH_W'(NCH - 1);
      grant_q       <= '0;
      err_q         <= '0;
      akey_q        <= '0;
      bkey_q        <= '0;
      rec_q         <= '0;
      key_ok_cnt    <= '0;
      key_abort_cnt <= '0;
    end else begin
      if (state_q == S_IDLE && state_d == S_GRANT) begin
        grant_q    <= arb_ch;
        last_grant <= arb_ch;
      end
      if (handshake) begin
        err_q  <= qk.qk_error[int'(grant_q)*ERR_W +: ERR_W];
        akey_q <= qk.qk_akey[int'(grant_q)*KEY_W +: KEY_W];
        bkey_q <= qk.qk_bkey[int'(grant_q)*KEY_W +: KEY_W];
      end
      if (state_q == S_CHECK) begin
        rec_q.ch  <= grant_q;
        rec_q.mm  <= mm;
        rec_q.err <= err_q;
        rec_q.key <= abort ? {KEY_W{1'b0}} : akey_q;
      end
      // Counters stick at all-ones rather than wrapping.
      if (fifo_push) begin
        if (rec_q.mm > MM_LIMIT) begin
          if (key_abort_cnt != 16'hFFFF) key_abort_cnt <= key_abort_cnt + 16'd1;
        end else begin
          if (key_ok_cnt != 16'hFFFF) key_ok_cnt <= key_ok_cnt + 16'd1;
        end
      end
    end
  end

  qk_rec_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (rec_q),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    logic [7:0] b1;
    b1 = {head.ch, head.mm};
    case (byte_idx)
      3'd0:    tx_byte = SYNC_BYTE;
      3'd1:    tx_byte = b1;
      3'd2:    tx_byte = head.err;
      3'd3:    tx_byte = head.key[31:24];
      3'd4:    tx_byte = head.key[23:16];
      3'd5:    tx_byte = head.key[15:8];
      3'd6:    tx_byte = head.key[7:0];
      default: tx_byte = b1 ^ head.err ^ head.key[31:24] ^ head.key[23:16]
                         ^ head.key[15:8] ^ head.key[7:0];
    endcase
  end

  assign qk.tx_valid = ~fifo_empty;
  assign qk.tx_data  = fifo_empty ? 8'h00 : tx_byte;
  assign fifo_pop    = qk.tx_valid & qk.tx_ready & (byte_idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (!rst) begin
      byte_idx <= '0;
    end else if (qk.tx_valid && qk.tx_ready) begin
      byte_idx <= (byte_idx == LAST_IDX) ? 3'd0 : byte_idx + 3'd1;
    end
  end

endmodule
